// File: rtl/typedefs.sv
// Shared payload types for the decode stage and its neighbours.
package typedefs;

    // One decoded instruction lane as handed to rename.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [6:0]  funct7;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } instStruct;

endpackage

// File: rtl/decode_stage_nw.sv
// N-wide decode stage between fetch/decode and rename: per-lane decode into
// instStruct, valid/ready handshake through an output register plus skid register.
module decode_stage_nw #(
    parameter int unsigned WIDTH    = 2,
    parameter bit          SIGN_EXT = 1'b1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [WIDTH-1:0]                    in_lane_mask,
    input  logic [WIDTH*32-1:0]                 in_inst,
    input  logic [WIDTH*32-1:0]                 in_pc,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH-1:0]                    out_lane_mask,
    output typedefs::instStruct [WIDTH-1:0]     out_inst,
    output logic [WIDTH-1:0]                    out_illegal,
    output logic                                illegal_seen,
    output logic [CNT_W-1:0]                    decoded_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_e;

    state_e                          state_q;
    logic                            in_ready_q;
    logic                            out_valid_q;
    logic [WIDTH-1:0]                out_mask_q;
    typedefs::instStruct [WIDTH-1:0] out_inst_q;
    logic [WIDTH-1:0]                out_ill_q;
    logic [WIDTH-1:0]                skid_mask_q;
    typedefs::instStruct [WIDTH-1:0] skid_inst_q;
    logic [WIDTH-1:0]                skid_ill_q;
    logic                            seen_q;
    logic [CNT_W-1:0]                count_q;

    typedefs::instStruct [WIDTH-1:0] dec_d;
    logic [WIDTH-1:0]                ill_d;
    logic [CNT_W-1:0]                count_d;
    logic [CNT_W-1:0]                pop_c;
    logic                            in_xfer;
    logic                            out_xfer;

    function automatic logic [31:0] ext12(input logic [11:0] v);
        return SIGN_EXT ? {{20{v[11]}}, v} : {20'd0, v};
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Fields are parsed for every opcode; control only for the supported set.
    function automatic typedefs::instStruct decode_lane(input logic [31:0] w,
                                                        input logic [31:0] pc);
        typedefs::instStruct d;
        d        = '0;
        d.opcode = w[6:0];
        d.rd     = w[11:7];
        d.funct3 = w[14:12];
        d.rs1    = w[19:15];
        d.rs2    = w[24:20];
        d.funct7 = w[31:25];
        d.pc     = pc;
        case (w[6:0])
            OP_R: begin
                d.alu_op    = 2'b10;
                d.reg_write = 1'b1;
            end
            OP_I: begin
                d.imm       = ext12(w[31:20]);
                d.alu_op    = 2'b11;
                d.alu_src   = 1'b1;
                d.reg_write = 1'b1;
            end
            OP_LOAD: begin
                d.imm        = ext12(w[31:20]);
                d.mem_read   = 1'b1;
                d.mem_to_reg = 1'b1;
                d.alu_src    = 1'b1;
                d.reg_write  = 1'b1;
            end
            OP_STORE: begin
                d.imm       = ext12({w[31:25], w[11:7]});
                d.mem_write = 1'b1;
                d.alu_src   = 1'b1;
            end
            default: ;
        endcase
        if (w[11:7] == 5'd0) d.reg_write = 1'b0;
        return d;
    endfunction

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            dec_d[i] = '0;
            ill_d[i] = 1'b0;
            if (in_lane_mask[i]) begin
                dec_d[i] = decode_lane(in_inst[32*i +: 32], in_pc[32*i +: 32]);
                ill_d[i] = !is_legal(in_inst[32*i +: 7]);
            end
        end
    end

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_c = pop_c + CNT_W'(out_mask_q[i]);
        end
        count_d = count_q + pop_c;
    end

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Buffer FSM; in_ready/out_valid are kept as registers alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_inst_q  <= '0;
            out_ill_q   <= '0;
            skid_mask_q <= '0;
            skid_inst_q <= '0;
            skid_ill_q  <= '0;
            seen_q      <= 1'b0;
            count_q     <= '0;
        end else if (flush) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (out_xfer) begin
                count_q <= count_d;
                if (|out_ill_q) seen_q <= 1'b1;
            end
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        out_mask_q  <= in_lane_mask;
                        out_inst_q  <= dec_d;
                        out_ill_q   <= ill_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (in_xfer && out_ready) begin
                        out_mask_q <= in_lane_mask;
                        out_inst_q <= dec_d;
                        out_ill_q  <= ill_d;
                    end else if (in_xfer) begin
                        skid_mask_q <= in_lane_mask;
                        skid_inst_q <= dec_d;
                        skid_ill_q  <= ill_d;
                        in_ready_q  <= 1'b0;
                        state_q     <= S_SKID;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (out_ready) begin
                        out_mask_q <= skid_mask_q;
                        out_inst_q <= skid_inst_q;
                        out_ill_q  <= skid_ill_q;
                        in_ready_q <= 1'b1;
                        state_q    <= S_FULL;
                    end
                end
                default: begin
                    state_q     <= S_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_lane_mask = out_mask_q;
    assign out_inst      = out_inst_q;
    assign out_illegal   = out_ill_q;
    assign illegal_seen  = seen_q;
    assign decoded_count = count_q;

    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_lane_mask) && $stable(out_inst) && $stable(out_illegal)));

    a_no_accept_in_skid: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_SKID) |-> !(in_valid && in_ready));

    a_illegal_in_mask: assert property (@(posedge clk) disable iff (reset)
        ((out_illegal & ~out_lane_mask) == '0));

endmodule
